// File: rtl/tdc_therm_decoder.sv
// tdc_therm_decoder: carry-chain snapshot to fine-time code, bubble flag and RAM write sequencing (optional majority filter: TDC_DEC_BUBBLE_FIX_EN)
module tdc_therm_decoder #(
  parameter int N = 16,
  parameter int N_WORDS = 8,
  parameter int INVERT = 0,
  localparam int CW = $clog2(N + 1),
  localparam int AW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [N-1:0]  therm,
  input  logic          start,
  output logic          out_valid,
  output logic [CW-1:0] code,
  output logic          bubble,
  output logic          write,
  output logic [AW-1:0] addr,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
  state_t state, state_n;
  logic [AW-1:0] addr_n;
  logic [N-1:0] s1_data, s2_corr, corr, inc;
  logic s1_valid, s2_valid, s2_bubble;
  logic [CW-1:0] pc;
`ifdef TDC_DEC_BUBBLE_FIX_EN
  logic [N+1:0] ext;
  assign ext = {1'b0, s1_data, 1'b1};
  for (genvar i = 0; i < N; i++) begin : g_maj
    assign corr[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
  end
`else
  assign corr = s1_data;
`endif
  assign inc = s1_data + N'(1);
  // Three-stage decode pipeline: capture, correct/classify, count
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      s1_data   <= '0;
      s1_valid  <= 1'b0;
      s2_corr   <= '0;
      s2_bubble <= 1'b0;
      s2_valid  <= 1'b0;
      code      <= '0;
      bubble    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s1_data   <= therm ^ {N{INVERT != 0}};
      s1_valid  <= in_valid;
      s2_corr   <= corr;
      s2_bubble <= (s1_data & inc) != '0;
      s2_valid  <= s1_valid;
      code      <= pc;
      bubble    <= s2_bubble;
      out_valid <= s2_valid;
    end
  // Population count of the corrected vector
  always_comb begin
    pc = '0;
    for (int i = 0; i < N; i++) pc = pc + CW'(s2_corr[i]);
  end
  // Run state and RAM address registers
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      addr  <= '0;
    end else begin
      state <= state_n;
      addr  <= addr_n;
    end
  // Run sequencing: start arms, each valid code writes one word, last word ends the run
  always_comb begin
    state_n = state;
    addr_n  = addr;
    unique case (state)
      IDLE, DONE:
        if (start) begin
          state_n = CAPTURE;
          addr_n  = '0;
        end
      CAPTURE:
        if (out_valid) begin
          if (addr == AW'(N_WORDS - 1)) state_n = DONE;
          else addr_n = addr + AW'(1);
        end
      default: state_n = IDLE;
    endcase
    write = out_valid && state == CAPTURE;
    done  = state == DONE;
  end
endmodule

// File: tb/tb_tdc_therm_decoder.sv
// tb_tdc_therm_decoder: directed checks of decode, bubble flag, run sequencing and async reset
module tb_tdc_therm_decoder;
  logic clock = 1'b0, reset = 1'b1, in_valid = 1'b0, start = 1'b0;
  logic [15:0] therm = '0;
  logic out_valid, bubble, write, done;
  logic [4:0] code;
  logic [2:0] addr;
  logic ov_i, bub_i, wr_i, dn_i;
  logic [4:0] code_i;
  logic [2:0] addr_i;
  int checks = 0, errors = 0;

  always #5 clock = ~clock;

  tdc_therm_decoder #(.N(16), .N_WORDS(8), .INVERT(0)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .therm(therm), .start(start),
    .out_valid(out_valid), .code(code), .bubble(bubble), .write(write), .addr(addr), .done(done)
  );

  tdc_therm_decoder #(.N(16), .N_WORDS(8), .INVERT(1)) dut_i (
    .clock(clock), .reset(reset), .in_valid(in_valid), .therm(therm), .start(start),
    .out_valid(ov_i), .code(code_i), .bubble(bub_i), .write(wr_i), .addr(addr_i), .done(dn_i)
  );

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] d);
    in_valid = 1'b1;
    therm = d;
    step;
    in_valid = 1'b0;
    therm = 16'h5555;
    step;
    step;
  endtask

  task automatic run(input logic [15:0] vin, input logic [15:0] stv, input int len);
    int wcnt = 0, ocnt = 0, fcnt = 0;
    logic ov, we;
    for (int s = 0; s < len; s++) begin
      in_valid = vin[s];
      start = stv[s];
      therm = vin[s] ? 16'((32'd1 << (fcnt + 1)) - 1) : 16'h5555;
      if (vin[s]) fcnt++;
      step;
      ov = (s >= 2) ? vin[s-2] : 1'b0;
      we = ov && wcnt < 8;
      chk("run_out_valid", out_valid, ov);
      if (ov) begin
        chk("run_code", code, ocnt + 1);
        ocnt++;
      end
      chk("run_write", write, we);
      chk("run_addr", addr, wcnt < 8 ? wcnt : 7);
      chk("run_done", done, wcnt == 8);
      if (we) wcnt++;
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    step;
    step;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_code", code, 0);
    chk("rst_bubble", bubble, 0);
    chk("rst_write", write, 0);
    chk("rst_addr", addr, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    step;
    in_valid = 1'b1;
    therm = 16'h00FF;
    step;
    in_valid = 1'b0;
    step;
    chk("latency_early", out_valid, 0);
    step;
    chk("ff_out_valid", out_valid, 1);
    chk("ff_code", code, 8);
    chk("ff_bubble", bubble, 0);
    chk("ff_write_idle", write, 0);
    send(16'h00F7);
`ifdef TDC_DEC_BUBBLE_FIX_EN
    chk("f7_code", code, 8);
`else
    chk("f7_code", code, 7);
`endif
    chk("f7_bubble", bubble, 1);
    send(16'h0000);
    chk("zero_code", code, 0);
    chk("zero_bubble", bubble, 0);
    send(16'hFFFF);
    chk("full_code", code, 16);
    chk("full_bubble", bubble, 0);
    chk("full_write_idle", write, 0);
    send(16'hFF00);
    chk("inv_out_valid", ov_i, 1);
    chk("inv_code", code_i, 8);
    chk("inv_bubble", bub_i, 0);
    chk("ff00_bubble_noninv", bubble, 1);
    run(16'h01FF, 16'h0001, 12);
    run(16'h03E7, 16'h0011, 13);
    for (int s = 0; s < 8; s++) begin
      in_valid = 1'b1;
      start = (s == 0);
      therm = 16'((32'd1 << (s + 1)) - 1);
      step;
    end
    start = 1'b0;
    chk("pre_rst_write", write, 1);
    chk("pre_rst_addr", addr, 5);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_code", code, 0);
    chk("arst_bubble", bubble, 0);
    chk("arst_write", write, 0);
    chk("arst_addr", addr, 0);
    chk("arst_done", done, 0);
    step;
    step;
    reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      step;
      chk("post_rst_write", write, 0);
      chk("post_rst_out_valid", out_valid, 0);
    end
    run(16'h00FF, 16'h0001, 11);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
